// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator stage and its result divider.
// ACC_LIMIT is the bound the upstream accumulator uses to stop growing y.
package accum_pkg;

  localparam int ACC_LIMIT = 300;
  localparam int W_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    HOLD = 2'd2
  } div_state_t;

endpackage

// File: rtl/accum_result_divider_if.sv
// Input and output channels of the accumulator result divider.
// Both channels: a beat transfers on a rising edge where valid && ready; the
// sender holds valid and payload stable until then, and ready may not depend on valid.
interface accum_result_divider_if
  import accum_pkg::*;
#(
  parameter int W = W_DEFAULT
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_q;
  logic [W-1:0] out_r;
  logic         out_div_zero;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_q, out_r, out_div_zero
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_q, out_r, out_div_zero
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit and
// subtract the divisor if it fits. Assumes rem < divisor on entry.
module div_step #(
  parameter int W = 15
) (
  input  logic [W-1:0] rem,
  input  logic         dbit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         qbit
);

  logic [W:0]   trial;
  logic [W-1:0] diff;

  assign trial = {rem, dbit};
  // When the subtraction is taken the result is below the divisor, so the
  // low W bits of the difference are exact.
  assign diff     = trial[W-1:0] - divisor;
  assign qbit     = trial[W] | (trial[W-1:0] >= divisor);
  assign rem_next = qbit ? diff : trial[W-1:0];

endmodule

// File: rtl/accum_result_divider.sv
// Divides the accumulator's final x by its final y with a W-cycle restoring
// divider and holds quotient/remainder on a valid/ready output.
module accum_result_divider
  import accum_pkg::*;
#(
  parameter  int W  = W_DEFAULT,
  localparam int CW = $clog2(W + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  accum_result_divider_if.slave  bus,
  output div_state_t             state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  divisor;
  logic [W-1:0]  dvd;
  logic [W-1:0]  rem;
  logic [W-1:0]  q_reg;
  logic [W-1:0]  r_reg;
  logic          valid_reg;
  logic          dz_reg;
  logic [W-1:0]  rem_next;
  logic          qbit;

  div_step #(.W(W)) u_step (
    .rem      (rem),
    .dbit     (dvd[W-1]),
    .divisor  (divisor),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // dvd doubles as the quotient register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      divisor   <= '0;
      dvd       <= '0;
      rem       <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      valid_reg <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            divisor <= bus.in_y;
            dvd     <= bus.in_x;
            rem     <= '0;
            if (bus.in_y == '0) begin
              q_reg     <= '1;
              r_reg     <= bus.in_x;
              dz_reg    <= 1'b1;
              valid_reg <= 1'b1;
              state     <= ST_HOLD;
            end else begin
              cnt   <= CW'(W);
              state <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          rem <= rem_next;
          dvd <= {dvd[W-2:0], qbit};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            q_reg     <= {dvd[W-2:0], qbit};
            r_reg     <= rem_next;
            dz_reg    <= 1'b0;
            valid_reg <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            valid_reg <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state == ST_IDLE);
  assign bus.out_valid    = valid_reg;
  assign bus.out_q        = q_reg;
  assign bus.out_r        = r_reg;
  assign bus.out_div_zero = dz_reg;
  assign state_dbg        = div_state_t'(state);

endmodule
